// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an async FIFO: Gray read pointer, empty/level flags,
// a 2-deep prefetch buffer feeding a valid/ready stream, and a CDC-integrity monitor.
module fifo_rd_ctrl #(
  parameter int ADDR_WIDTH    = 4,
  parameter int DATA_WIDTH    = 8,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  rclk,
  input  logic                  rrst,
  input  logic [ADDR_WIDTH:0]   rq2_wptr,
  output logic [ADDR_WIDTH:0]   rptr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  rempty,
  output logic                  ralmost_empty,
  output logic [ADDR_WIDTH:0]   rlevel,
  output logic                  wptr_cdc_err,
  input  logic                  err_clr
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AE_TH = PW'(AEMPTY_THRESH);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // A legal synchronized Gray pointer moves by at most one bit per sample.
  function automatic logic multi_bit_change(input logic [PW-1:0] a, input logic [PW-1:0] b);
    logic [PW-1:0] d;
    d = a ^ b;
    return (d & (d - PW'(1))) != '0;
  endfunction

  logic [PW-1:0]         rbin_r;
  logic [PW-1:0]         rptr_r;
  logic                  rempty_r;
  logic                  ralmost_empty_r;
  logic [PW-1:0]         rlevel_r;
  logic [PW-1:0]         wq_prev_r;
  logic                  cdc_err_r;
  logic [1:0]            occ_r;
  logic                  inflight_r;
  logic [DATA_WIDTH-1:0] buf0_r;
  logic [DATA_WIDTH-1:0] buf1_r;

  logic                  dout_valid_s;
  logic                  pop_s;
  logic [2:0]            demand_s;
  logic                  ren_s;
  logic [PW-1:0]         rbin_next_s;
  logic [PW-1:0]         rgray_next_s;
  logic [PW-1:0]         wbin_s;
  logic [PW-1:0]         rlevel_next_s;
  logic                  cdc_det_s;
  logic [1:0]            occ_next_s;
  logic [1:0]            slot_s;
  logic [DATA_WIDTH-1:0] head_s;
  logic [DATA_WIDTH-1:0] buf0_next_s;
  logic [DATA_WIDTH-1:0] buf1_next_s;

  assign dout_valid_s  = (occ_r != 2'd0);
  assign dout_valid    = dout_valid_s;
  assign dout          = buf0_r;
  assign mem_ren       = ren_s;
  assign raddr         = rbin_r[ADDR_WIDTH-1:0];
  assign rptr          = rptr_r;
  assign rempty        = rempty_r;
  assign ralmost_empty = ralmost_empty_r;
  assign rlevel        = rlevel_r;
  assign wptr_cdc_err  = cdc_err_r;

  // Issue a read only when the word is guaranteed a buffer slot on arrival.
  always_comb begin
    pop_s    = dout_valid_s & dout_ready;
    demand_s = {1'b0, occ_r} + {2'b00, inflight_r} - {2'b00, pop_s};
    if (rrst) begin
      ren_s = 1'b0;
    end else if (rempty_r) begin
      ren_s = 1'b0;
    end else if (demand_s < 3'd2) begin
      ren_s = 1'b1;
    end else begin
      ren_s = 1'b0;
    end
  end

  // Next read pointer, fill level and write-pointer integrity check.
  always_comb begin
    rbin_next_s   = rbin_r + {{ADDR_WIDTH{1'b0}}, ren_s};
    rgray_next_s  = bin2gray(rbin_next_s);
    wbin_s        = gray2bin(rq2_wptr);
    rlevel_next_s = wbin_s - rbin_next_s;
    cdc_det_s     = multi_bit_change(rq2_wptr, wq_prev_r);
  end

  // In-order buffer: pop shifts the tail to the head, arriving data fills the first free slot.
  always_comb begin
    occ_next_s  = occ_r + {1'b0, inflight_r} - {1'b0, pop_s};
    slot_s      = occ_r - {1'b0, pop_s};
    head_s      = pop_s ? buf1_r : buf0_r;
    buf0_next_s = (inflight_r && (slot_s == 2'd0)) ? mem_rdata : head_s;
    buf1_next_s = (inflight_r && (slot_s == 2'd1)) ? mem_rdata : buf1_r;
  end

  // Pointer, flag and buffer state; clearing inflight on reset discards late read data.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin_r          <= '0;
      rptr_r          <= '0;
      rempty_r        <= 1'b1;
      ralmost_empty_r <= 1'b1;
      rlevel_r        <= '0;
      occ_r           <= 2'd0;
      inflight_r      <= 1'b0;
      buf0_r          <= '0;
      buf1_r          <= '0;
    end else begin
      rbin_r          <= rbin_next_s;
      rptr_r          <= rgray_next_s;
      rempty_r        <= (rgray_next_s == rq2_wptr);
      ralmost_empty_r <= (rlevel_next_s <= AE_TH);
      rlevel_r        <= rlevel_next_s;
      occ_r           <= occ_next_s;
      inflight_r      <= ren_s;
      buf0_r          <= buf0_next_s;
      buf1_r          <= buf1_next_s;
    end
  end

  // Sticky CDC error; a fresh detection outranks a simultaneous clear.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      wq_prev_r <= '0;
      cdc_err_r <= 1'b0;
    end else begin
      wq_prev_r <= rq2_wptr;
      if (cdc_det_s) begin
        cdc_err_r <= 1'b1;
      end else if (err_clr) begin
        cdc_err_r <= 1'b0;
      end else begin
        cdc_err_r <= cdc_err_r;
      end
    end
  end

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: queue-based read-side model checked every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fifo_rd_ctrl;

  logic       rclk = 1'b0;
  logic       rrst;
  logic [4:0] rq2_wptr;
  logic [4:0] rptr;
  logic [3:0] raddr;
  logic       mem_ren;
  logic [7:0] mem_rdata;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       rempty;
  logic       ralmost_empty;
  logic [4:0] rlevel;
  logic       wptr_cdc_err;
  logic       err_clr;

  logic [7:0] mem [16];
  int n_cmp = 0;
  int n_fail = 0;

  fifo_rd_ctrl dut (
    .rclk(rclk), .rrst(rrst), .rq2_wptr(rq2_wptr), .rptr(rptr), .raddr(raddr),
    .mem_ren(mem_ren), .mem_rdata(mem_rdata), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .rempty(rempty), .ralmost_empty(ralmost_empty),
    .rlevel(rlevel), .wptr_cdc_err(wptr_cdc_err), .err_clr(err_clr)
  );

  always #5 rclk = ~rclk;

  // Synchronous memory: data one cycle after the strobe, junk otherwise.
  always @(posedge rclk) mem_rdata <= mem_ren ? mem[raddr] : 8'hEE;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] gray5(input int b);
    return 5'(b ^ (b >> 1));
  endfunction

  function automatic int ungray(input logic [4:0] g);
    for (int b = 0; b < 32; b++) begin
      if (gray5(b) == g) return b;
    end
    return 0;
  endfunction

  // Reference model: words read so far, in-flight words and buffered words as queues.
  initial begin
    logic [7:0] mbuf[$];
    logic [7:0] mfly[$];
    int rd_cnt;
    logic m_empty, m_aempty, m_err;
    logic [4:0] m_level, m_prev;
    bit armed, pop, exp_ren;
    int dem;
    armed = 1'b0; rd_cnt = 0; m_empty = 1'b1; m_aempty = 1'b1; m_err = 1'b0;
    m_level = 5'd0; m_prev = 5'd0;
    forever begin
      @(negedge rclk);
      pop = (mbuf.size() != 0) && (dout_ready === 1'b1);
      dem = mbuf.size() + mfly.size() - (pop ? 1 : 0);
      exp_ren = (rrst === 1'b0) && !m_empty && (dem < 2);
      if (armed) begin
        chk("m_dout_valid", dout_valid, mbuf.size() != 0);
        if (mbuf.size() != 0) chk("m_dout", dout, mbuf[0]);
        chk("m_mem_ren", mem_ren, exp_ren);
        if (exp_ren) chk("m_raddr", raddr, rd_cnt % 16);
        chk("m_rptr", rptr, gray5(rd_cnt));
        chk("m_rempty", rempty, m_empty);
        chk("m_rlevel", rlevel, m_level);
        chk("m_ralmost_empty", ralmost_empty, m_aempty);
        chk("m_cdc_err", wptr_cdc_err, m_err);
      end
      if (rrst === 1'b1) begin
        mbuf.delete(); mfly.delete();
        rd_cnt = 0; m_empty = 1'b1; m_aempty = 1'b1; m_level = 5'd0;
        m_err = 1'b0; m_prev = 5'd0; armed = 1'b1;
      end else begin
        if (pop) void'(mbuf.pop_front());
        if (mfly.size() != 0) begin
          mbuf.push_back(mfly[0]);
          mfly.delete();
        end
        if (exp_ren) begin
          mfly.push_back(mem[rd_cnt % 16]);
          rd_cnt = (rd_cnt + 1) % 32;
        end
        m_empty  = (gray5(rd_cnt) == rq2_wptr);
        m_level  = 5'((ungray(rq2_wptr) - rd_cnt + 32) % 32);
        m_aempty = (m_level <= 5'd2);
        if ($countones(rq2_wptr ^ m_prev) > 1) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        m_prev = rq2_wptr;
      end
    end
  end

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic look();
    #1;
  endtask

  // Directed scenarios; inputs change 1 time unit after the edge.
  initial begin
    int nv, first, last, nr;
    rrst = 1'b1; rq2_wptr = 5'd0; dout_ready = 1'b0; err_clr = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    tick(); tick();
    rrst = 1'b0;

    // Idle after reset with an empty write pointer
    for (int k = 0; k < 6; k++) begin
      tick(); look();
      chk("idle rempty", rempty, 1'b1);
      chk("idle ralmost_empty", ralmost_empty, 1'b1);
      chk("idle mem_ren", mem_ren, 1'b0);
      chk("idle dout_valid", dout_valid, 1'b0);
      chk("idle rptr", rptr, 5'h00);
      chk("idle rlevel", rlevel, 5'h00);
      chk("idle dout", dout, 8'h00);
      chk("idle cdc_err", wptr_cdc_err, 1'b0);
    end

    // First-word latency
    mem[0] = 8'hA5;
    tick(); rq2_wptr = 5'h01; look();
    chk("T rempty", rempty, 1'b1);
    tick(); look();
    chk("T+1 rempty", rempty, 1'b0);
    chk("T+1 mem_ren", mem_ren, 1'b1);
    chk("T+1 raddr", raddr, 4'h0);
    tick(); look();
    chk("T+2 rempty", rempty, 1'b1);
    chk("T+2 dout_valid", dout_valid, 1'b0);
    tick(); look();
    chk("T+3 dout_valid", dout_valid, 1'b1);
    chk("T+3 dout", dout, 8'hA5);
    tick(); dout_ready = 1'b1; look();
    tick(); dout_ready = 1'b0; look();
    chk("drained dout_valid", dout_valid, 1'b0);

    // Full-depth burst at one word per cycle
    tick(); rrst = 1'b1; rq2_wptr = 5'h00;
    for (int i = 0; i < 16; i++) mem[i] = 8'(i);
    tick(); rrst = 1'b0; rq2_wptr = 5'h18; dout_ready = 1'b1;
    nv = 0; first = -1; last = -1;
    for (int c = 1; c <= 24; c++) begin
      tick(); look();
      if (dout_valid) begin
        if (first < 0) first = c;
        last = c;
        chk("burst word", dout, nv);
        nv++;
      end
    end
    chk("burst count", nv, 16);
    chk("burst first cycle", first, 3);
    chk("burst no gaps", last - first + 1, 16);
    chk("burst rptr", rptr, 5'h18);
    chk("burst rempty", rempty, 1'b1);
    tick(); err_clr = 1'b1; look();
    tick(); err_clr = 1'b0; look();
    chk("burst err cleared", wptr_cdc_err, 1'b0);

    // Back-pressure with 8 words present
    tick(); rrst = 1'b1; rq2_wptr = 5'h00; dout_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h40 + i);
    tick(); rrst = 1'b0; rq2_wptr = 5'h0C;
    nr = 0;
    for (int c = 0; c < 8; c++) begin
      tick(); look();
      if (mem_ren) nr++;
      if (dout_valid) chk("held dout", dout, 8'h40);
    end
    chk("held reads", nr, 2);
    chk("held dout_valid", dout_valid, 1'b1);
    chk("held rlevel", rlevel, 5'd6);
    chk("held ralmost_empty", ralmost_empty, 1'b0);
    tick(); dout_ready = 1'b1;
    nv = 0; first = -1; last = -1;
    for (int c = 0; c < 12; c++) begin
      if (c != 0) tick();
      look();
      if (dout_valid) begin
        if (first < 0) first = c;
        last = c;
        chk("release word", dout, 8'h40 + nv);
        nv++;
      end
    end
    chk("release count", nv, 8);
    chk("release no gaps", last - first + 1, 8);

    // CDC error detection, hold and clear
    tick(); rrst = 1'b1; rq2_wptr = 5'h00; dout_ready = 1'b0;
    tick(); rrst = 1'b0; rq2_wptr = 5'h03; look();
    chk("cdc before", wptr_cdc_err, 1'b0);
    tick(); look();
    chk("cdc set", wptr_cdc_err, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick(); look();
      chk("cdc held", wptr_cdc_err, 1'b1);
    end
    tick(); err_clr = 1'b1; look();
    chk("cdc during clr", wptr_cdc_err, 1'b1);
    tick(); err_clr = 1'b0; look();
    chk("cdc cleared", wptr_cdc_err, 1'b0);

    // Reset with a full buffer and a read in flight
    tick(); rrst = 1'b1; rq2_wptr = 5'h00; dout_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 8'(8'h80 + i);
    tick(); rrst = 1'b0; rq2_wptr = 5'h02;
    repeat (4) tick();
    dout_ready = 1'b1; look();
    chk("pre-reset mem_ren", mem_ren, 1'b1);
    chk("pre-reset dout_valid", dout_valid, 1'b1);
    chk("pre-reset dout", dout, 8'h80);
    tick(); rrst = 1'b1; rq2_wptr = 5'h00; dout_ready = 1'b0; look();
    chk("in-reset mem_ren", mem_ren, 1'b0);
    tick(); rrst = 1'b0; look();
    chk("post-reset dout_valid", dout_valid, 1'b0);
    chk("post-reset rptr", rptr, 5'h00);
    chk("post-reset rempty", rempty, 1'b1);
    for (int k = 0; k < 4; k++) begin
      tick(); look();
      chk("no stale word", dout_valid, 1'b0);
    end

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_ctrl.md
FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 4, giving the FIFO memory address width (depth 2^ADDR_WIDTH).
REQ-002 SHALL have parameter DATA_WIDTH, default 8, giving the word width.
REQ-003 SHALL have parameter AEMPTY_THRESH, default 2, giving the almost-empty level threshold.
REQ-004 SHALL have port rclk, input, 1, the read-domain clock; this is the block's only clock.
REQ-005 SHALL have port rrst, input, 1, reset: synchronous to rclk, active-high.
REQ-006 SHALL have port rq2_wptr, input, ADDR_WIDTH+1, the Gray write pointer already 2-flop synchronized into rclk.
REQ-007 SHALL have port rptr, output, ADDR_WIDTH+1, the registered Gray read pointer sent to the write domain.
REQ-008 SHALL have port raddr, output, ADDR_WIDTH, the binary memory read address (low bits of the binary read pointer).
REQ-009 SHALL have port mem_ren, output, 1, the memory read strobe.
REQ-010 SHALL have port mem_rdata, input, DATA_WIDTH, memory data, valid exactly 1 cycle after mem_ren.
REQ-011 SHALL have ports dout (output, DATA_WIDTH), dout_valid (output, 1) and dout_ready (input, 1), the consumer valid/ready stream.
REQ-012 SHALL have port rempty, output, 1, registered pointer-empty flag.
REQ-013 SHALL have ports ralmost_empty (output, 1) and rlevel (output, ADDR_WIDTH+1), the registered fill indicators.
REQ-014 SHALL have ports wptr_cdc_err (output, 1, sticky CDC-integrity error) and err_clr (input, 1, clears it).

Function
REQ-015 SHALL keep a binary read pointer rbin (ADDR_WIDTH+1 bits) and rptr = (rbin>>1)^rbin, registered; both wrap modulo 2^(ADDR_WIDTH+1).
REQ-016 SHALL assert mem_ren combinationally iff !rempty and (occ + inflight - pop) < 2, where occ = output-buffer entries (0..2), inflight = mem_ren of the previous cycle, and pop = dout_valid & dout_ready.
REQ-017 SHALL increment rbin in each cycle mem_ren is 1, with raddr = rbin[ADDR_WIDTH-1:0] in that cycle.
REQ-018 SHALL register rempty <= (rgraynext == rq2_wptr), where rgraynext is the Gray encoding of rbin after this cycle's increment.
REQ-019 SHALL capture mem_rdata into a 2-entry in-order output buffer 1 cycle after mem_ren; dout is the head entry and dout_valid = (occ != 0).
REQ-020 SHALL hold dout stable while dout_valid is 1 and dout_ready is 0; the buffer never overflows and never drops or reorders words.
REQ-021 SHALL sustain 1 word/cycle with dout_ready held at 1 and the FIFO non-empty.
REQ-022 SHALL produce first-word latency as follows: rq2_wptr leaves the empty value in cycle T, rempty falls in T+1, mem_ren rises in T+1, dout_valid rises in T+3.
REQ-023 SHALL register rlevel <= gray2bin(rq2_wptr) - rbin_next (modulo 2^(ADDR_WIDTH+1)), counting words still in memory and excluding the buffer and in-flight reads.
REQ-024 SHALL register ralmost_empty <= (rlevel_next <= AEMPTY_THRESH).
REQ-025 SHALL register rq2_wptr once more, and SHALL set wptr_cdc_err when the current and previous values differ in more than one bit.
REQ-026 SHALL clear wptr_cdc_err on err_clr; a new error detected in the same cycle as err_clr SHALL win, leaving wptr_cdc_err at 1.
REQ-027 SHALL treat a full wrap (rbin MSB toggling) as normal: rempty is determined by all ADDR_WIDTH+1 bits.

Reset
REQ-028 SHALL, on rrst=1 at a rclk edge, set rbin=0, rptr=0, rempty=1, ralmost_empty=1, rlevel=0, occ=0, inflight=0, dout_valid=0, dout=0 and wptr_cdc_err=0.
REQ-029 SHALL hold mem_ren at 0 while rrst=1.
REQ-030 SHALL discard any mem_rdata returning in the cycle after reset, including data from a read issued before reset.
REQ-031 SHALL require the write domain to be reset in the same reset event; in a reset mid-operation all buffered and in-flight words are lost.

Verification
REQ-032 SHALL cover: reset, then rq2_wptr=0 held -> rempty=1, ralmost_empty=1, mem_ren=0, dout_valid=0 indefinitely.
REQ-033 SHALL cover: rq2_wptr 0->1 in cycle T with mem[0]=0xA5 -> rempty=0 at T+1, mem_ren=1 with raddr=0 at T+1, dout=0xA5 and dout_valid=1 at T+3, rempty=1 from T+2.
REQ-034 SHALL cover: 16 words 0x00..0x0F, rq2_wptr=Gray(16), dout_ready=1 -> 16 consecutive dout_valid cycles in order, rptr=Gray(16)=0x18, then rempty=1.
REQ-035 SHALL cover: dout_ready=0 with 8 words present -> exactly 2 reads issued, dout stable at the first word, rlevel=6; on release, the remaining words arrive in order with no gaps.
REQ-036 SHALL cover: rq2_wptr jumps 0x00->0x03 -> wptr_cdc_err=1 the next cycle, held through idle cycles, cleared by a 1-cycle err_clr pulse.
REQ-037 SHALL cover: rrst pulsed while 2 words are buffered and 1 read is in flight -> the next cycle has dout_valid=0, rptr=0, rempty=1, and the stale mem_rdata is never presented.
